// File: rtl/sram_master_pkg.sv
// rtl/sram_master_pkg.sv - shared sizes, FSM state type and byte-enable expansion for sram_64x64_master
// Contents:
//   SRAM_AW/SRAM_DW/SRAM_BEW/SRAM_DEPTH - SRAM geometry
//   RSP_DEPTH                           - read response FIFO depth
//   state_t                             - controller state (INIT sweep, RUN traffic)
//   be_to_mask                          - byte enables to per-bit write mask
package sram_master_pkg;

    localparam int SRAM_AW    = 6;
    localparam int SRAM_DW    = 64;
    localparam int SRAM_BEW   = 8;
    localparam int SRAM_DEPTH = 64;
    localparam int RSP_DEPTH  = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [SRAM_DW-1:0] be_to_mask(input logic [SRAM_BEW-1:0] be);
        logic [SRAM_DW-1:0] mask;
        for (int k = 0; k < SRAM_BEW; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sram_64x64_master_if.sv
// rtl/sram_64x64_master_if.sv - request, response and SRAM-side signal bundle for sram_64x64_master
// Signals:
//   i_req_valid/o_req_ready/i_req_we/i_req_addr/i_req_wdata/i_req_be - request channel
//   o_rsp_valid/i_rsp_ready/o_rsp_rdata                               - read response channel
//   o_sram_cen/o_sram_wen/o_sram_bit_mask/o_sram_addr/o_sram_wdata    - SRAM command
//   i_sram_rdata                                                      - SRAM read data (one cycle latency)
//   o_init_done                                                       - memory ready for traffic
// Modports: master = controller side, slave = requester/SRAM environment side.
interface sram_64x64_master_if;
    import sram_master_pkg::*;

    logic                i_req_valid;
    logic                o_req_ready;
    logic                i_req_we;
    logic [SRAM_AW-1:0]  i_req_addr;
    logic [SRAM_DW-1:0]  i_req_wdata;
    logic [SRAM_BEW-1:0] i_req_be;

    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic [SRAM_DW-1:0]  o_rsp_rdata;

    logic                o_sram_cen;
    logic                o_sram_wen;
    logic [SRAM_DW-1:0]  o_sram_bit_mask;
    logic [SRAM_AW-1:0]  o_sram_addr;
    logic [SRAM_DW-1:0]  o_sram_wdata;
    logic [SRAM_DW-1:0]  i_sram_rdata;

    logic                o_init_done;

    modport master (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be,
        input  i_rsp_ready, i_sram_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata,
        output o_sram_cen, o_sram_wen, o_sram_bit_mask, o_sram_addr, o_sram_wdata,
        output o_init_done
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be,
        output i_rsp_ready, i_sram_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata,
        input  o_sram_cen, o_sram_wen, o_sram_bit_mask, o_sram_addr, o_sram_wdata,
        input  o_init_done
    );

endinterface

// File: rtl/sram_master_rsp_fifo.sv
// rtl/sram_master_rsp_fifo.sv - two-entry read response FIFO
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_data - enqueue request and data
//   pop             - dequeue head (ignored when empty)
//   valid, data     - head entry present / head data
//   count           - current occupancy 0..2
module sram_master_rsp_fifo
    import sram_master_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [SRAM_DW-1:0] push_data,
    input  logic               pop,
    output logic               valid,
    output logic [SRAM_DW-1:0] data,
    output logic [1:0]         count
);

    localparam int PW = $clog2(RSP_DEPTH);

    logic [SRAM_DW-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [1:0]         occ;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop & (occ != 2'd0);
    // A full FIFO still accepts a push in the cycle it is popped.
    assign do_push = push & ((occ != 2'(RSP_DEPTH)) | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign valid = (occ != 2'd0);
    assign data  = mem[rd_ptr];
    assign count = occ;

endmodule

// File: rtl/sram_64x64_master.sv
// rtl/sram_64x64_master.sv - credit-limited request/response master for a 64x64 single-port SRAM
// Optional power-on clear sweep of all words: define SRAM_MASTER_INIT_EN.
// Ports:
//   i_clk - clock, all state on rising edge
//   i_rst - asynchronous active-high reset
//   bus   - request, response and SRAM signals (sram_64x64_master_if.master)
module sram_64x64_master
    import sram_master_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    sram_64x64_master_if.master bus
);

    state_t             state;
    logic [SRAM_AW-1:0] init_addr;
    logic               rd_inflight;
    logic               fifo_valid;
    logic [SRAM_DW-1:0] fifo_data;
    logic [1:0]         fifo_count;
    logic [1:0]         credit;
    logic               in_run;
    logic               req_fire;
    logic               rsp_fire;

`ifdef SRAM_MASTER_INIT_EN
    state_t             state_next;
    logic [SRAM_AW-1:0] init_addr_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state     <= state_next;
            init_addr <= init_addr_next;
        end
    end

    always_comb begin
        state_next     = state;
        init_addr_next = init_addr;
        if (state == ST_INIT) begin
            init_addr_next = init_addr + 1'b1;
            if (init_addr == SRAM_AW'(SRAM_DEPTH - 1)) begin
                state_next = ST_RUN;
            end
        end
    end

    assign bus.o_init_done = (state == ST_RUN);
`else
    assign state           = ST_RUN;
    assign init_addr       = '0;
    assign bus.o_init_done = 1'b1;
`endif

    // Credits cover both buffered responses and the read whose data is
    // still on its way back from the SRAM, so the FIFO can never overflow.
    assign credit   = fifo_count + {1'b0, rd_inflight};
    assign rsp_fire = fifo_valid & bus.i_rsp_ready;
    assign in_run   = (state == ST_RUN) & ~i_rst;

    // A full credit pool frees one slot in the same cycle a response leaves.
    assign bus.o_req_ready = in_run & ((credit < 2'd2) | ((credit == 2'd2) & rsp_fire));
    assign req_fire        = bus.i_req_valid & bus.o_req_ready;

    always_comb begin
        bus.o_sram_cen      = 1'b0;
        bus.o_sram_wen      = bus.i_req_we;
        bus.o_sram_bit_mask = '0;
        bus.o_sram_addr     = bus.i_req_addr;
        bus.o_sram_wdata    = bus.i_req_wdata;
        if (!i_rst && (state == ST_INIT)) begin
            bus.o_sram_cen      = 1'b1;
            bus.o_sram_wen      = 1'b1;
            bus.o_sram_bit_mask = '1;
            bus.o_sram_addr     = init_addr;
            bus.o_sram_wdata    = '0;
        end else begin
            bus.o_sram_cen = req_fire;
            if (bus.i_req_we) begin
                bus.o_sram_bit_mask = be_to_mask(bus.i_req_be);
            end
        end
    end

    // SRAM data for a read accepted last cycle is valid now; capture it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= req_fire & ~bus.i_req_we;
        end
    end

    sram_master_rsp_fifo u_rsp_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (rd_inflight),
        .push_data (bus.i_sram_rdata),
        .pop       (rsp_fire),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .count     (fifo_count)
    );

    assign bus.o_rsp_valid = fifo_valid;
    assign bus.o_rsp_rdata = fifo_data;

endmodule

// File: tb/tb_sram_64x64_master.sv
// tb/tb_sram_64x64_master.sv - self-checking bench for sram_64x64_master
module tb_sram_64x64_master;
    import sram_master_pkg::*;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp_rdata;
    } vec_t;

    localparam int NV = 14;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    sram_64x64_master_if bus ();

    sram_64x64_master dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // SRAM model: masked write, registered read data.
    logic [63:0] sram_mem [64];
    logic [63:0] sram_q;
    always @(posedge i_clk) begin
        if (bus.o_sram_cen) begin
            if (bus.o_sram_wen)
                sram_mem[bus.o_sram_addr] <= (sram_mem[bus.o_sram_addr] & ~bus.o_sram_bit_mask)
                                           | (bus.o_sram_wdata & bus.o_sram_bit_mask);
            else
                sram_q <= sram_mem[bus.o_sram_addr];
        end
    end
    assign bus.i_sram_rdata = sram_q;

    // Reference model: memory contents and outstanding reads in order.
    logic [63:0] ref_mem [64];
    logic [63:0] exp_q [$];
    int          acc_q [$];
    logic        hold_pending = 1'b0;
    logic [63:0] hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] exp_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = be[i / 8];
        return m;
    endfunction

    task automatic step(input logic v, input logic we, input logic [5:0] a, input logic [63:0] wd,
                        input logic [7:0] be, input logic rr,
                        output logic acc, output logic popped, output logic [63:0] pdata);
        int outstanding;
        logic pop;
        @(negedge i_clk);
        bus.i_req_valid = v;
        bus.i_req_we    = we;
        bus.i_req_addr  = a;
        bus.i_req_wdata = wd;
        bus.i_req_be    = be;
        bus.i_rsp_ready = rr;
        #1;
        outstanding = exp_q.size();
        pop         = bus.o_rsp_valid & rr;
        if (hold_pending) begin
            check("rsp_hold_valid", bus.o_rsp_valid, 1);
            check("rsp_hold_data", bus.o_rsp_rdata, hold_data);
        end
        check("req_ready", bus.o_req_ready, (outstanding < 2) || (outstanding == 2 && pop));
        acc = v & bus.o_req_ready;
        check("sram_cen", bus.o_sram_cen, acc);
        if (acc) begin
            check("sram_wen", bus.o_sram_wen, we);
            check("sram_addr", bus.o_sram_addr, a);
            check("sram_wdata", bus.o_sram_wdata, wd);
            check("sram_mask", bus.o_sram_bit_mask, we ? exp_mask(be) : 64'h0);
        end
        popped = 1'b0;
        pdata  = bus.o_rsp_rdata;
        if (bus.o_rsp_valid) begin
            if (exp_q.size() == 0) check("rsp_spurious", bus.o_rsp_valid, 0);
            else check("rsp_early", (cyc - acc_q[0]) >= 2, 1);
        end
        if (pop && exp_q.size() > 0) begin
            check("rsp_data", bus.o_rsp_rdata, exp_q.pop_front());
            void'(acc_q.pop_front());
            popped = 1'b1;
        end
        hold_pending = bus.o_rsp_valid & ~rr;
        hold_data    = bus.o_rsp_rdata;
        if (acc) begin
            if (we) begin
                for (int k = 0; k < 8; k++)
                    if (be[k]) ref_mem[a][8*k +: 8] = wd[8*k +: 8];
            end else begin
                exp_q.push_back(ref_mem[a]);
                acc_q.push_back(cyc);
            end
        end
        cyc++;
    endtask

    task automatic issue(input logic we, input logic [5:0] a, input logic [63:0] wd, input logic [7:0] be);
        logic acc, pp;
        logic [63:0] pd;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, we, a, wd, be, 1'b1, acc, pp, pd);
        if (!acc) check("issue_timeout", acc, 1);
    endtask

    task automatic drain();
        logic acc, pp;
        logic [63:0] pd;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1'b0, 1'b0, 6'd0, 64'h0, 8'h0, 1'b1, acc, pp, pd);
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic sweep_check(input int upto);
        for (int i = 0; i < upto; i++) begin
            if (i != 0) @(negedge i_clk);
            #1;
            check("init_cen", bus.o_sram_cen, 1);
            check("init_wen", bus.o_sram_wen, 1);
            check("init_mask", bus.o_sram_bit_mask, 64'hFFFF_FFFF_FFFF_FFFF);
            check("init_wdata", bus.o_sram_wdata, 64'h0);
            check("init_addr", bus.o_sram_addr, i);
            check("init_ready", bus.o_req_ready, 0);
            check("init_done_low", bus.o_init_done, 0);
        end
    endtask

    task automatic assert_reset();
        @(negedge i_clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = 1'b0;
        bus.i_rsp_ready = 1'b1;
        i_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k != 0) @(negedge i_clk);
            #1;
            check("rst_cen", bus.o_sram_cen, 0);
            check("rst_ready", bus.o_req_ready, 0);
            check("rst_rsp_valid", bus.o_rsp_valid, 0);
        end
    endtask

    task automatic release_reset();
        i_rst = 1'b0;
        bus.i_req_valid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        hold_pending = 1'b0;
        #1;
        check("post_rst_rsp_valid", bus.o_rsp_valid, 0);
`ifdef SRAM_MASTER_INIT_EN
        bus.i_req_valid = 1'b1;
        sweep_check(64);
        @(negedge i_clk);
        bus.i_req_valid = 1'b0;
        #1;
        check("init_done_rise", bus.o_init_done, 1);
        check("run_ready", bus.o_req_ready, 1);
        for (int i = 0; i < 64; i++) ref_mem[i] = 64'h0;
`else
        check("init_done_tied", bus.o_init_done, 1);
        check("run_ready", bus.o_req_ready, 1);
`endif
    endtask

    initial begin
        vec_t        tbl [NV];
        logic        acc, pp, got;
        logic [63:0] pd;
        logic [63:0] seen [$];
        int          lat;

        tbl[0]  = '{1'b1, 6'd5,  64'h0,                  8'hFF, 64'h0};
        tbl[1]  = '{1'b1, 6'd5,  64'h1122334455667788,   8'h0F, 64'h0};
        tbl[2]  = '{1'b0, 6'd5,  64'h0,                  8'h00, 64'h0000000055667788};
        tbl[3]  = '{1'b1, 6'd5,  64'hFFFFFFFFFFFFFFFF,   8'h00, 64'h0};
        tbl[4]  = '{1'b0, 6'd5,  64'h0,                  8'h00, 64'h0000000055667788};
        tbl[5]  = '{1'b1, 6'd5,  64'hAABBCCDDEEFF0011,   8'hF0, 64'h0};
        tbl[6]  = '{1'b0, 6'd5,  64'h0,                  8'h00, 64'hAABBCCDD55667788};
        tbl[7]  = '{1'b1, 6'd63, 64'h0123456789ABCDEF,   8'hFF, 64'h0};
        tbl[8]  = '{1'b0, 6'd63, 64'h0,                  8'h00, 64'h0123456789ABCDEF};
        tbl[9]  = '{1'b1, 6'd0,  64'h0,                  8'hFF, 64'h0};
        tbl[10] = '{1'b1, 6'd0,  64'hFEDCBA9876543210,   8'h81, 64'h0};
        tbl[11] = '{1'b0, 6'd0,  64'h0,                  8'h00, 64'hFE00000000000010};
        tbl[12] = '{1'b1, 6'd62, 64'hFFFFFFFFFFFFFFFF,   8'h55, 64'h0};
        tbl[13] = '{1'b0, 6'd62, 64'h0,                  8'h00, 64'h00FF00FF00FF00FF};

        bus.i_req_valid = 1'b0;
        bus.i_req_we    = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_wdata = '0;
        bus.i_req_be    = '0;
        bus.i_rsp_ready = 1'b0;

        assert_reset();
        release_reset();

`ifndef SRAM_MASTER_INIT_EN
        for (int i = 0; i < 64; i++) issue(1'b1, 6'(i), {$urandom, $urandom}, 8'hFF);
`endif
        // Prior content of word 62 is zeroed before the masked write.
        issue(1'b1, 6'd62, 64'h0, 8'hFF);

        for (int t = 0; t < NV; t++) begin
            issue(tbl[t].we, tbl[t].addr, tbl[t].wdata, tbl[t].be);
            if (!tbl[t].we) begin
                got = 1'b0;
                lat = 0;
                for (int k = 0; k < 10 && !got; k++) begin
                    step(1'b0, 1'b0, 6'd0, 64'h0, 8'h0, 1'b1, acc, pp, pd);
                    lat++;
                    got = pp;
                end
                check("tbl_rsp_seen", got, 1);
                check("tbl_rdata", pd, tbl[t].exp_rdata);
                check("tbl_latency", lat, 2);
            end
        end

        // Backpressure: two reads fit, the third waits for a pop.
        issue(1'b1, 6'd10, 64'hA0A0A0A0A0A0A0A0, 8'hFF);
        issue(1'b1, 6'd11, 64'hB1B1B1B1B1B1B1B1, 8'hFF);
        issue(1'b1, 6'd12, 64'hC2C2C2C2C2C2C2C2, 8'hFF);
        step(1'b1, 1'b0, 6'd10, 64'h0, 8'h0, 1'b0, acc, pp, pd);
        check("bp_acc_a", acc, 1);
        step(1'b1, 1'b0, 6'd11, 64'h0, 8'h0, 1'b0, acc, pp, pd);
        check("bp_acc_b", acc, 1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 6'd12, 64'h0, 8'h0, 1'b0, acc, pp, pd);
            check("bp_stall_c", acc, 0);
        end
        step(1'b1, 1'b0, 6'd12, 64'h0, 8'h0, 1'b1, acc, pp, pd);
        check("bp_resume_c", acc, 1);
        check("bp_first_rsp", pd, 64'hA0A0A0A0A0A0A0A0);
        seen.delete();
        for (int k = 0; k < 10 && seen.size() < 2; k++) begin
            step(1'b0, 1'b0, 6'd0, 64'h0, 8'h0, 1'b1, acc, pp, pd);
            if (pp) seen.push_back(pd);
        end
        check("bp_rsp_count", seen.size(), 2);
        if (seen.size() == 2) begin
            check("bp_second_rsp", seen[0], 64'hB1B1B1B1B1B1B1B1);
            check("bp_third_rsp", seen[1], 64'hC2C2C2C2C2C2C2C2);
        end

        // Streaming reads with the consumer always ready: one per cycle.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 6'(i * 3), 64'h0, 8'h0, 1'b1, acc, pp, pd);
            check("stream_acc", acc, 1);
        end
        drain();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom), 6'($urandom), {$urandom, $urandom},
                 8'($urandom), $urandom_range(0, 3) != 0, acc, pp, pd);
        drain();

        // Reset with reads buffered and in flight discards them.
        step(1'b1, 1'b0, 6'd1, 64'h0, 8'h0, 1'b0, acc, pp, pd);
        step(1'b1, 1'b0, 6'd2, 64'h0, 8'h0, 1'b0, acc, pp, pd);
        assert_reset();
        release_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'd0, 64'h0, 8'h0, 1'b1, acc, pp, pd);

`ifdef SRAM_MASTER_INIT_EN
        // Reset at sweep address 30 restarts the sweep from 0.
        assert_reset();
        i_rst = 1'b0;
        bus.i_req_valid = 1'b0;
        sweep_check(31);
        i_rst = 1'b1;
        #1;
        check("midsweep_rst_cen", bus.o_sram_cen, 0);
        check("midsweep_rst_ready", bus.o_req_ready, 0);
        check("midsweep_rst_done", bus.o_init_done, 0);
        @(negedge i_clk);
        release_reset();
`endif

        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 1) != 0, 1'($urandom), 6'($urandom), {$urandom, $urandom},
                 8'($urandom), $urandom_range(0, 2) != 0, acc, pp, pd);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_64x64_master.md
SRAM_64X64_MASTER -- requirements
Module: sram_64x64_master

Interface
REQ-001 SHALL provide ports:
  i_clk  input  1  clock, all state on rising edge
  i_rst  input  1  reset, asynchronous, active-high
  i_req_valid  input  1  request valid
  o_req_ready  output  1  request accepted when valid&ready
  i_req_we  input  1  1=write, 0=read
  i_req_addr  input  6  word address
  i_req_wdata  input  64  write data
  i_req_be  input  8  byte enables, writes only
  o_rsp_valid  output  1  read response valid
  i_rsp_ready  input  1  response consumed when valid&ready
  o_rsp_rdata  output  64  read data
  o_sram_cen  output  1  SRAM enable, active-high
  o_sram_wen  output  1  SRAM write enable, active-high
  o_sram_bit_mask  output  64  per-bit write mask, 1=write
  o_sram_addr  output  6  SRAM address
  o_sram_wdata  output  64  SRAM write data
  i_sram_rdata  input  64  SRAM read data, valid one cycle after read enable
  o_init_done  output  1  memory ready for traffic
REQ-002 Clock and reset SHALL be one clock; reset asynchronous and active-high, ports i_clk and i_rst.

Function
REQ-003 SRAM outputs SHALL be combinational from the accepted request: o_sram_cen = i_req_valid & o_req_ready in RUN.
REQ-004 o_sram_wen SHALL equal i_req_we; o_sram_addr/o_sram_wdata pass through.
REQ-005 o_sram_bit_mask[8k+j] SHALL equal i_req_be[k], k=0..7, j=0..7; reads drive mask 0.
REQ-006 A write with i_req_be=0 SHALL be accepted and issued, changing no bits.
REQ-007 Writes SHALL produce no response.
REQ-008 Read accepted in cycle N: i_sram_rdata sampled end of N+1 into the response FIFO; o_rsp_valid earliest in N+2.
REQ-009 Response FIFO SHALL hold 2 entries; responses return in request order.
REQ-010 Credit count = FIFO occupancy + in-flight read (0/1), range 0..2.
REQ-011 o_req_ready SHALL be 1 in RUN when count<2, or count==2 with o_rsp_valid&i_rsp_ready the same cycle; else 0.
REQ-012 Writes SHALL obey the same ready rule.
REQ-013 Simultaneous push and pop SHALL keep occupancy unchanged, data order preserved.
REQ-014 o_rsp_valid/o_rsp_rdata SHALL hold stable while i_rsp_ready=0.
REQ-015 FSM states INIT and RUN; INIT->RUN after the last init write; RUN is terminal until reset.

Reset
REQ-016 On i_rst: FIFO empty, count 0, o_rsp_valid=0, init address 0, state INIT (macro on) or RUN (off).
REQ-017 Reset mid-INIT SHALL restart the sweep at address 0; reset with reads in flight SHALL discard them.
REQ-018 During reset o_sram_cen and o_req_ready SHALL be 0.

Configuration
REQ-019 Macro SRAM_MASTER_INIT_EN defined: INIT writes 0 to addresses 0..63, one per cycle, full mask; o_req_ready=0 and o_init_done=0 until RUN.
REQ-020 Macro undefined: no INIT state, reset enters RUN, o_init_done tied 1.

Structure
REQ-021 Package sram_master_pkg SHALL hold SRAM_AW=6, SRAM_DW=64, SRAM_BEW=8, SRAM_DEPTH=64, RSP_DEPTH=2 and the FSM state enum.
REQ-022 Response FIFO SHALL be sub-module sram_master_rsp_fifo, 2 entries, 64-bit.

Verification
REQ-023 Macro on, reset release -> 64 cycles cen=1,wen=1,mask=all-ones,data=0, addr 0..63; o_init_done rises the next cycle.
REQ-024 Write addr 5 data 0x1122334455667788 be=0x0F, then read 5 -> rsp 0x0000000055667788 (after init), 2 cycles after read accept.
REQ-025 i_rsp_ready=0, three back-to-back reads -> two accepted, third stalls; assert ready -> responses in order, third accepted.
REQ-026 Continuous reads with i_rsp_ready=1 -> one read accepted every cycle after fill, no drops.
REQ-027 Assert i_rst at sweep address 30 -> after release sweep restarts at address 0, FIFO empty, o_rsp_valid=0.
